// File: rtl/instruction_fetch_unit.sv
// Fetch stage for MiniALU: PC drives the combinational ROM and fields are registered. Address-to-issue latency is 1 cycle; JMP costs one bubble.
// iStall freezes the PC and the issued fields. FETCH_NOP_DELAY_EN turns a NOP literal N into N wait bubbles with oWaiting high.
module instruction_fetch_unit #(
  parameter logic [15:0] PC_RESET   = 16'd0,
  parameter int          WAIT_WIDTH = 24,
  parameter logic [3:0]  OP_NOP     = 4'd0,
  parameter logic [3:0]  OP_JMP     = 4'd12
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic        oValid,
  output logic [3:0]  oOpcode,
  output logic [7:0]  oDest,
  output logic [7:0]  oSrc1,
  output logic [7:0]  oSrc0,
  output logic [15:0] oLiteral,
  output logic        oWaiting
);

  if (WAIT_WIDTH < 1 || WAIT_WIDTH > 24) begin : g_width_check
    $error("WAIT_WIDTH must lie within the 24-bit NOP literal");
  end

  logic [15:0] pc;
  logic        valid;
  logic [3:0]  opcode;
  logic [7:0]  dest;
  logic [7:0]  src1;
  logic [7:0]  src0;
  logic [15:0] literal;
  logic        is_jmp;
  logic        in_wait;

  assign is_jmp = (iInstruction[27:24] == OP_JMP);

`ifdef FETCH_NOP_DELAY_EN
  typedef enum logic {ST_FETCH, ST_WAIT} state_t;

  state_t                state;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  waiting;
  logic [WAIT_WIDTH-1:0] nop_len;
  logic                  is_nop;

  assign nop_len = iInstruction[WAIT_WIDTH-1:0];
  assign is_nop  = (iInstruction[27:24] == OP_NOP);
  assign in_wait = (state == ST_WAIT);

  // oWaiting marks exactly the bubble cycles, not the cycle the NOP itself is issued
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      waiting  <= 1'b0;
    end else if (iBranchTaken) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      waiting  <= 1'b0;
    end else if (state == ST_WAIT) begin
      waiting  <= 1'b1;
      wait_cnt <= wait_cnt - 1'b1;
      if (wait_cnt == WAIT_WIDTH'(1))
        state <= ST_FETCH;
    end else begin
      waiting <= 1'b0;
      if (!iStall && is_nop && (nop_len != '0)) begin
        state    <= ST_WAIT;
        wait_cnt <= nop_len;
      end
    end
  end

  assign oWaiting = waiting;
`else
  assign in_wait  = 1'b0;
  assign oWaiting = 1'b0;
`endif

  // Priority: reset, redirect, wait bubble, stall, local JMP, then normal issue
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc      <= PC_RESET;
      valid   <= 1'b0;
      opcode  <= '0;
      dest    <= '0;
      src1    <= '0;
      src0    <= '0;
      literal <= '0;
    end else if (iBranchTaken) begin
      pc    <= iBranchTarget;
      valid <= 1'b0;
    end else if (in_wait) begin
      valid <= 1'b0;
    end else if (iStall) begin
      pc    <= pc;
      valid <= valid;
    end else if (is_jmp) begin
      pc    <= {8'b0, iInstruction[23:16]};
      valid <= 1'b0;
    end else begin
      pc      <= pc + 16'd1;
      valid   <= 1'b1;
      opcode  <= iInstruction[27:24];
      dest    <= iInstruction[23:16];
      src1    <= iInstruction[15:8];
      src0    <= iInstruction[7:0];
      literal <= iInstruction[15:0];
    end
  end

  assign oAddress = pc;
  assign oValid   = valid;
  assign oOpcode  = opcode;
  assign oDest    = dest;
  assign oSrc1    = src1;
  assign oSrc0    = src0;
  assign oLiteral = literal;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random stall/branch/reset traffic against a bubble-count reference model.
module tb_instruction_fetch_unit;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_STO = 4'd2;
  localparam logic [3:0] OP_JMP = 4'd12;

  logic        Clock;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDest;
  logic [7:0]  oSrc1;
  logic [7:0]  oSrc0;
  logic [15:0] oLiteral;
  logic        oWaiting;

  logic [27:0] rom [256];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the issued word, the PC and how many bubbles are still owed
  logic [15:0] m_pc;
  logic        m_valid;
  logic [27:0] m_word;
  int          m_bub;
  logic        m_wait;

  instruction_fetch_unit #(
    .PC_RESET  (16'd0),
    .WAIT_WIDTH(24),
    .OP_NOP    (OP_NOP),
    .OP_JMP    (OP_JMP)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oAddress     (oAddress),
    .iInstruction (iInstruction),
    .iStall       (iStall),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget),
    .oValid       (oValid),
    .oOpcode      (oOpcode),
    .oDest        (oDest),
    .oSrc1        (oSrc1),
    .oSrc0        (oSrc0),
    .oLiteral     (oLiteral),
    .oWaiting     (oWaiting)
  );

  assign iInstruction = rom[oAddress[7:0]];

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic stall, input logic br, input logic [15:0] tgt);
    logic [27:0] w;
    w = rom[m_pc[7:0]];
    Reset         = rst;
    iStall        = stall;
    iBranchTaken  = br;
    iBranchTarget = tgt;
    if (rst) begin
      m_pc = 16'd0; m_valid = 1'b0; m_word = '0; m_bub = 0; m_wait = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_valid = 1'b0; m_bub = 0; m_wait = 1'b0;
    end else if (m_bub > 0) begin
      m_bub--; m_valid = 1'b0; m_wait = 1'b1;
    end else begin
      m_wait = 1'b0;
      if (!stall) begin
        if (w[27:24] == OP_JMP) begin
          m_pc = {8'h00, w[23:16]}; m_valid = 1'b0;
        end else begin
          m_word = w; m_valid = 1'b1; m_pc = m_pc + 16'd1;
`ifdef FETCH_NOP_DELAY_EN
          if (w[27:24] == OP_NOP) m_bub = int'(w[23:0]);
`endif
        end
      end
    end
    @(posedge Clock);
    #1;
    chk("addr", oAddress, m_pc);
    chk("valid", oValid, m_valid);
    chk("fields", {oOpcode, oDest, oSrc1, oSrc0}, m_word);
    chk("literal", oLiteral, m_word[15:0]);
    chk("waiting", oWaiting, m_wait);
    if (oValid) chk("no_jmp_issued", oOpcode == OP_JMP, 1'b0);
  endtask

  logic [3:0]  op;
  int unsigned k;
  logic        r_rst, r_stall, r_br;
  logic [15:0] r_tgt;

  initial begin
    Clock = 1'b0; Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;
    m_pc = '0; m_valid = 1'b0; m_word = '0; m_bub = 0; m_wait = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = {OP_ADD, 8'(a), 8'(a + 1), 8'(a + 2)};
    rom[3]  = {OP_STO, 8'd7, 8'd0, 8'd3};
    rom[14] = {OP_JMP, 8'd2, 16'h0000};

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_addr", oAddress, 16'd0);
    chk("rst_valid", oValid, 1'b0);
    chk("rst_fields", {oOpcode, oDest, oSrc1, oSrc0, oLiteral}, 44'd0);
    chk("rst_wait", oWaiting, 1'b0);

    // Straight-line fetch 0..3
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0);
      chk("seq_addr", oAddress, 16'(i));
      chk("seq_valid", oValid, 1'b1);
    end
    chk("sto_dest", oDest, 8'd7);
    chk("sto_opcode", oOpcode, OP_STO);

    // JMP at 14 goes to 2 with one bubble
    step(0, 0, 1, 16'd13);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("jmp_addr", oAddress, 16'd2);
    chk("jmp_bubble", oValid, 1'b0);
    step(0, 0, 0, 0);
    chk("jmp_next", {oOpcode, oDest}, {OP_ADD, 8'd2});

    // Branch redirect while PC=10 squashes that word
    step(0, 0, 1, 16'd10);
    step(0, 0, 1, 16'd5);
    chk("br_addr", oAddress, 16'd5);
    chk("br_squash", oValid, 1'b0);
    step(0, 0, 0, 0);
    chk("br_issue", oDest, 8'd5);

    // Stall for three cycles after issuing address 8
    step(0, 0, 1, 16'd8);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall_addr", oAddress, 16'd9);
      chk("stall_valid", oValid, 1'b1);
      chk("stall_dest", oDest, 8'd8);
    end
    step(0, 0, 0, 0);
    chk("stall_release", oAddress, 16'd10);

    // NOP with literal 4 at address 0
    rom[0] = {OP_NOP, 24'd4};
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("nop_issue", {oValid, oOpcode}, {1'b1, OP_NOP});
`ifdef FETCH_NOP_DELAY_EN
    for (int i = 0; i < 4; i++) begin
      step(0, (i == 1), 0, 0);
      chk("nop_wait_valid", oValid, 1'b0);
      chk("nop_wait_flag", oWaiting, 1'b1);
    end
`endif
    step(0, 0, 0, 0);
    chk("nop_after", {oValid, oDest, oWaiting}, {1'b1, 8'd1, 1'b0});

    // PC wrap
    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 0, 0);
    chk("wrap_addr", oAddress, 16'h0000);

    // Reset in the middle of a wait
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_mid_addr", oAddress, 16'd0);
    chk("rst_mid_wait", oWaiting, 1'b0);

    // Random traffic over several ROM images
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 256; a++) begin
        k = $urandom_range(0, 9);
        if (k == 0) rom[a] = {OP_JMP, 8'($urandom), 16'($urandom)};
        else if (k == 1) rom[a] = {OP_NOP, 24'($urandom_range(0, 5))};
        else begin
          op = 4'($urandom_range(1, 15));
          if (op == OP_JMP) op = 4'd13;
          rom[a] = {op, 24'($urandom)};
        end
      end
      step(1, 0, 0, 0);
      for (int c = 0; c < 600; c++) begin
        r_rst   = ($urandom_range(0, 199) == 0);
        r_stall = ($urandom_range(0, 3) == 0);
        r_br    = ($urandom_range(0, 19) == 0);
        r_tgt   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
        step(r_rst, r_stall, r_br, r_tgt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
